// File: rtl/vx_commit_arbiter.sv
// Purpose : round-robin arbiter merging NUM_REQS commit streams onto one writeback port,
//           holding the grant on a requester across a multi-beat commit until its eop beat.
// Latency : 1 cycle from request fire to wb_valid; 1 beat/cycle sustained with wb_ready high.
// Backpr. : wb_valid && !wb_ready freezes the output registers, arbiter state and all req_ready.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset
//   req_valid/ready      per-requester beat handshake (one ready bit high at most)
//   req_wis/rd/eop/data  per-requester beat fields, packed requester-major
//   wb_*                 registered writeback beat; wb_sel names the source requester
//   stall_cycles         wrapping count of cycles with pending requests but no fire
module vx_commit_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 64,
  parameter int WIS_W    = 2,
  parameter int NR_W     = 6,
  parameter int CTR_W    = 32,
  localparam int SEL_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*WIS_W-1:0] req_wis,
  input  logic [NUM_REQS*NR_W-1:0]  req_rd,
  input  logic [NUM_REQS-1:0]       req_eop,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      wb_valid,
  output logic [WIS_W-1:0]          wb_wis,
  output logic [NR_W-1:0]           wb_rd,
  output logic                      wb_eop,
  output logic [DATAW-1:0]          wb_data,
  output logic [SEL_W-1:0]          wb_sel,
  input  logic                      wb_ready,
  output logic [CTR_W-1:0]          stall_cycles
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] lock_idx;

  logic             load_en;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] grant_next;
  logic             fire;
  logic [WIS_W-1:0] sel_wis;
  logic [NR_W-1:0]  sel_rd;
  logic             sel_eop;
  logic [DATAW-1:0] sel_data;

  assign load_en = !wb_valid || wb_ready;

  // Grant selection. Scanning offsets from high to low lets the smallest
  // offset from rr_ptr overwrite the others, giving rotating priority.
  always_comb begin
    int j;
    j         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (state == LOCKED) begin
      // Grant stays on the locked requester even across its valid gaps.
      grant_vld = 1'b1;
      grant_idx = lock_idx;
    end else begin
      for (int k = NUM_REQS - 1; k >= 0; k--) begin
        j = int'(rr_ptr) + k;
        if (j >= NUM_REQS) j = j - NUM_REQS;
        if (req_valid[j]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(j);
        end
      end
    end
  end

  // Field mux and ready decode from the granted index.
  always_comb begin
    sel_wis   = '0;
    sel_rd    = '0;
    sel_eop   = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        sel_wis  = req_wis[i*WIS_W +: WIS_W];
        sel_rd   = req_rd[i*NR_W +: NR_W];
        sel_eop  = req_eop[i];
        sel_data = req_data[i*DATAW +: DATAW];
      end
      req_ready[i] = load_en && grant_vld && (grant_idx == SEL_W'(i));
    end
  end

  assign fire       = |(req_valid & req_ready);
  assign grant_next = (grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else if (fire) begin
      if (sel_eop) begin
        state  <= IDLE;
        rr_ptr <= grant_next;
      end else begin
        state    <= LOCKED;
        lock_idx <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_wis   <= '0;
      wb_rd    <= '0;
      wb_eop   <= 1'b0;
      wb_data  <= '0;
      wb_sel   <= '0;
    end else if (fire) begin
      wb_valid <= 1'b1;
      wb_wis   <= sel_wis;
      wb_rd    <= sel_rd;
      wb_eop   <= sel_eop;
      wb_data  <= sel_data;
      wb_sel   <= grant_idx;
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (|req_valid && !fire) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Directed bench for vx_commit_arbiter (4 requesters, 4-bit stall counter).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_vx_commit_arbiter;
  localparam int NUM_REQS = 4;
  localparam int DATAW    = 64;
  localparam int WIS_W    = 2;
  localparam int NR_W     = 6;
  localparam int CTR_W    = 4;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQS-1:0]       req_valid;
  logic [NUM_REQS*WIS_W-1:0] req_wis;
  logic [NUM_REQS*NR_W-1:0]  req_rd;
  logic [NUM_REQS-1:0]       req_eop;
  logic [NUM_REQS*DATAW-1:0] req_data;
  logic [NUM_REQS-1:0]       req_ready;
  logic                      wb_valid;
  logic [WIS_W-1:0]          wb_wis;
  logic [NR_W-1:0]           wb_rd;
  logic                      wb_eop;
  logic [DATAW-1:0]          wb_data;
  logic [1:0]                wb_sel;
  logic                      wb_ready;
  logic [CTR_W-1:0]          stall_cycles;

  int tests = 0;
  int fails = 0;

  vx_commit_arbiter #(
    .NUM_REQS(NUM_REQS), .DATAW(DATAW), .WIS_W(WIS_W), .NR_W(NR_W), .CTR_W(CTR_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wis(req_wis), .req_rd(req_rd), .req_eop(req_eop),
    .req_data(req_data), .req_ready(req_ready),
    .wb_valid(wb_valid), .wb_wis(wb_wis), .wb_rd(wb_rd), .wb_eop(wb_eop),
    .wb_data(wb_data), .wb_sel(wb_sel), .wb_ready(wb_ready),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic eop,
                         input logic [NR_W-1:0] rd, input logic [DATAW-1:0] data);
    req_valid[i]               = v;
    req_eop[i]                 = eop;
    req_wis[i*WIS_W +: WIS_W]  = WIS_W'(i);
    req_rd[i*NR_W +: NR_W]     = rd;
    req_data[i*DATAW +: DATAW] = data;
  endtask

  task automatic chk_wb(input string tag, input logic [1:0] sel,
                        input logic [NR_W-1:0] rd, input logic [DATAW-1:0] data);
    chk({tag, "_valid"}, 64'(wb_valid), 64'd1);
    chk({tag, "_sel"},   64'(wb_sel),   64'(sel));
    chk({tag, "_rd"},    64'(wb_rd),    64'(rd));
    chk({tag, "_data"},  wb_data,       data);
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_wis   = '0;
    req_rd    = '0;
    req_eop   = '0;
    req_data  = '0;
    wb_ready  = 1'b1;

    // Reset state
    #3;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_wb_sel",   64'(wb_sel),   64'd0);
    chk("rst_wb_data",  wb_data,       64'd0);
    chk("rst_stall",    64'(stall_cycles), 64'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    tick();

    // Single beats: req0 rd=5 then req2 rd=9
    set_req(0, 1'b1, 1'b1, 6'd5, 64'hA0);
    set_req(2, 1'b1, 1'b1, 6'd9, 64'hA2);
    #1 chk("sb_ready0", 64'(req_ready), 64'b0001);
    tick();
    chk_wb("sb_beat0", 2'd0, 6'd5, 64'hA0);
    set_req(0, 1'b0, 1'b1, 6'd0, 64'h0);
    #1 chk("sb_ready1", 64'(req_ready), 64'b0100);
    tick();
    chk_wb("sb_beat1", 2'd2, 6'd9, 64'hA2);
    set_req(2, 1'b0, 1'b1, 6'd0, 64'h0);
    // rr_ptr should now be 3: req3 beats req0
    set_req(0, 1'b1, 1'b1, 6'd1, 64'hB0);
    set_req(3, 1'b1, 1'b1, 6'd3, 64'hB3);
    #1 chk("rr3_ready", 64'(req_ready), 64'b1000);
    tick();
    chk_wb("rr3_beat", 2'd3, 6'd3, 64'hB3);
    set_req(0, 1'b0, 1'b1, 6'd0, 64'h0);
    set_req(3, 1'b0, 1'b1, 6'd0, 64'h0);
    tick();
    chk("idle_valid", 64'(wb_valid), 64'd0);
    chk("sb_stall",   64'(stall_cycles), 64'd0);

    // Fairness: rr_ptr=0, all four valid for 8 cycles
    for (int i = 0; i < NUM_REQS; i++) set_req(i, 1'b1, 1'b1, 6'(10 + i), 64'h100 + 64'(i));
    for (int c = 0; c < 8; c++) begin
      #1 chk("fair_ready", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      tick();
      chk_wb("fair_beat", 2'(c % 4), 6'(10 + c % 4), 64'h100 + 64'(c % 4));
    end
    chk("fair_stall", 64'(stall_cycles), 64'd0);
    req_valid = '0;
    tick();

    // Packet lock: advance rr_ptr to 1 with a lone req0 beat
    set_req(0, 1'b1, 1'b1, 6'd20, 64'hC0);
    tick();
    chk_wb("pk_pre", 2'd0, 6'd20, 64'hC0);
    set_req(3, 1'b1, 1'b1, 6'd23, 64'hC3);
    set_req(1, 1'b1, 1'b0, 6'd21, 64'hD1);
    #1 chk("pk_ready_b1", 64'(req_ready), 64'b0010);
    tick();
    chk_wb("pk_b1", 2'd1, 6'd21, 64'hD1);
    set_req(1, 1'b1, 1'b0, 6'd21, 64'hD2);
    #1 chk("pk_ready_b2", 64'(req_ready), 64'b0010);
    tick();
    chk_wb("pk_b2", 2'd1, 6'd21, 64'hD2);
    set_req(1, 1'b0, 1'b0, 6'd21, 64'hD2);
    #1 chk("pk_ready_gap", 64'(req_ready), 64'b0010);
    tick();
    chk("pk_gap_valid", 64'(wb_valid), 64'd0);
    chk("pk_gap_stall", 64'(stall_cycles), 64'd1);
    set_req(1, 1'b1, 1'b1, 6'd21, 64'hD3);
    #1 chk("pk_ready_b3", 64'(req_ready), 64'b0010);
    tick();
    chk_wb("pk_b3", 2'd1, 6'd21, 64'hD3);
    chk("pk_b3_eop", 64'(wb_eop), 64'd1);
    set_req(1, 1'b0, 1'b1, 6'd0, 64'h0);
    #1 chk("pk_ready_next", 64'(req_ready), 64'b1000);
    tick();
    chk_wb("pk_next", 2'd3, 6'd23, 64'hC3);

    // Backpressure: hold for 4 cycles with req0 and req3 pending, rr_ptr=0
    wb_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 chk("bp_ready", 64'(req_ready), 64'd0);
      tick();
      chk_wb("bp_hold", 2'd3, 6'd23, 64'hC3);
    end
    chk("bp_stall", 64'(stall_cycles), 64'd5);
    wb_ready = 1'b1;
    #1 chk("bp_ready_rel", 64'(req_ready), 64'b0001);
    tick();
    chk_wb("bp_next", 2'd0, 6'd20, 64'hC0);
    chk("bp_stall_after", 64'(stall_cycles), 64'd5);

    // Async reset while locked on req2 (rr_ptr=1)
    req_valid = '0;
    set_req(2, 1'b1, 1'b0, 6'd30, 64'hE2);
    #1 chk("ar_ready", 64'(req_ready), 64'b0100);
    tick();
    chk_wb("ar_lock", 2'd2, 6'd30, 64'hE2);
    #2 reset = 1'b0;
    #1;
    chk("ar_wb_valid", 64'(wb_valid), 64'd0);
    chk("ar_stall",    64'(stall_cycles), 64'd0);
    set_req(0, 1'b1, 1'b1, 6'd31, 64'hF0);
    set_req(2, 1'b1, 1'b1, 6'd32, 64'hF2);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("ar_ready_post", 64'(req_ready), 64'b0001);
    tick();
    chk_wb("ar_first", 2'd0, 6'd31, 64'hF0);

    // Counter wrap: req2 pending while output is held
    set_req(0, 1'b0, 1'b1, 6'd0, 64'h0);
    wb_ready = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    chk("wrap_15", 64'(stall_cycles), 64'd15);
    tick();
    chk("wrap_0", 64'(stall_cycles), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
